tcam_pipelined: RTL

//  Parametrised, fully pipelined TCAM that replaces the single-cycle tcam wrapper in

---
 rtl/tcam_pipelined.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/tcam_pipelined.sv
// rtl/tcam_pipelined.sv - pipelined TCAM with valid bits, clear sweep, tagged lookups and multi-match
module tcam_pipelined #(
    parameter int C_TCAM_ADDR_WIDTH = 5,
    parameter int C_TCAM_DATA_WIDTH = 32,
    parameter int C_TAG_WIDTH       = 8
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         WE,
    input  logic                         INVALIDATE,
    input  logic [C_TCAM_ADDR_WIDTH-1:0] WR_ADDR,
    input  logic [C_TCAM_DATA_WIDTH-1:0] DIN,
    input  logic [C_TCAM_DATA_WIDTH-1:0] DATA_MASK,
    input  logic                         CLR,
    output logic                         BUSY,
    input  logic                         CMP_VALID,
    input  logic [C_TCAM_DATA_WIDTH-1:0] CMP_DIN,
    input  logic [C_TCAM_DATA_WIDTH-1:0] CMP_DATA_MASK,
    input  logic [C_TAG_WIDTH-1:0]       CMP_TAG,
    output logic                         RES_VALID,
    output logic [C_TAG_WIDTH-1:0]       RES_TAG,
    output logic                         MATCH,
    output logic                         MULTI_MATCH,
    output logic [C_TCAM_ADDR_WIDTH-1:0] MATCH_ADDR
);
    localparam int AW    = C_TCAM_ADDR_WIDTH;
    localparam int DW    = C_TCAM_DATA_WIDTH;
    localparam int TW    = C_TAG_WIDTH;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t               state;
    logic [AW-1:0]        sweep_addr;
    logic [DEPTH-1:0]     entry_valid;
    logic [DW-1:0]        entry_data [DEPTH];
    logic [DW-1:0]        entry_mask [DEPTH];

    logic                 s1_valid;
    logic [DW-1:0]        s1_key;
    logic [DW-1:0]        s1_mask;
    logic [TW-1:0]        s1_tag;

    logic                 s2_valid;
    logic [DEPTH-1:0]     s2_hit;
    logic [TW-1:0]        s2_tag;

    logic [DEPTH-1:0]     hit_vec;
    logic [AW-1:0]        enc_addr;
    logic                 enc_match;
    logic                 enc_multi;
    logic                 enc_seen;

    assign BUSY = (state == ST_SWEEP);

    // Reset behaves like a CLR that cannot be ignored: the sweep starts as reset releases.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_SWEEP;
            sweep_addr  <= '0;
            entry_valid <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CLR) begin
                        state       <= ST_SWEEP;
                        sweep_addr  <= '0;
                        entry_valid <= '0;
                    end else if (WE) begin
                        entry_valid[WR_ADDR] <= !INVALIDATE;
                    end
                end
                ST_SWEEP: begin
                    sweep_addr <= sweep_addr + 1'b1;
                    if (sweep_addr == {AW{1'b1}}) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Entry storage carries no reset; the valid bits alone decide whether an entry can hit.
    always_ff @(posedge CLK) begin
        if (state == ST_SWEEP) begin
            entry_data[sweep_addr] <= '0;
            entry_mask[sweep_addr] <= '0;
        end else if (WE && !CLR && !INVALIDATE && !RESET) begin
            entry_data[WR_ADDR] <= DIN;
            entry_mask[WR_ADDR] <= DATA_MASK;
        end
    end

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = entry_valid[i] &&
                         (((s1_key ^ entry_data[i]) & ~entry_mask[i] & ~s1_mask) == '0);
        end
    end

    always_comb begin
        enc_addr  = '0;
        enc_match = |s2_hit;
        enc_multi = 1'b0;
        enc_seen  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (s2_hit[i]) begin
                enc_addr = AW'(i);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (s2_hit[i]) begin
                if (enc_seen) begin
                    enc_multi = 1'b1;
                end
                enc_seen = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_valid    <= 1'b0;
            s1_key      <= '0;
            s1_mask     <= '0;
            s1_tag      <= '0;
            s2_valid    <= 1'b0;
            s2_hit      <= '0;
            s2_tag      <= '0;
            RES_VALID   <= 1'b0;
            RES_TAG     <= '0;
            MATCH       <= 1'b0;
            MULTI_MATCH <= 1'b0;
            MATCH_ADDR  <= '0;
        end else begin
            s1_valid    <= CMP_VALID;
            s1_key      <= CMP_DIN;
            s1_mask     <= CMP_DATA_MASK;
            s1_tag      <= CMP_TAG;
            s2_valid    <= s1_valid;
            s2_hit      <= hit_vec;
            s2_tag      <= s1_tag;
            RES_VALID   <= s2_valid;
            RES_TAG     <= s2_tag;
            MATCH       <= enc_match;
            MULTI_MATCH <= enc_multi;
            MATCH_ADDR  <= enc_addr;
        end
    end
endmodule
